// File: rtl/adder_osc_meter_pkg.sv
// Shared types and constants for the adder ring-oscillator measurement controller.
package adder_osc_meter_pkg;

   // Measurement controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   // Flops in the ring_i synchroniser ahead of the edge detector
   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/adder_osc_meter_if.sv
// Control/data bundle between the LA/IO wrapper (master) and adder_osc_meter (slave).
// Optional build macro: ADDER_OSC_METER_MINMAX_EN adds clear_stats, min_count, max_count.
interface adder_osc_meter_if #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned COUNT_W  = 16,
   parameter int unsigned WINDOW_W = 16
);
   logic                start;
   logic                abort;
   logic [WINDOW_W-1:0] window_cycles;
   logic [WIDTH-1:0]    input_a;
   logic [WIDTH-1:0]    xor_enable;
   logic [WIDTH-1:0]    add_enable;
   logic                ring_i;
   logic [WIDTH-1:0]    adder_a_o;
   logic [WIDTH-1:0]    xor_en_o;
   logic [WIDTH-1:0]    add_en_o;
   logic                busy;
   logic                done;
   logic [COUNT_W-1:0]  count;
   logic                overflow;
`ifdef ADDER_OSC_METER_MINMAX_EN
   logic                clear_stats;
   logic [COUNT_W-1:0]  min_count;
   logic [COUNT_W-1:0]  max_count;
`endif

   modport master (
`ifdef ADDER_OSC_METER_MINMAX_EN
      output clear_stats,
      input  min_count, max_count,
`endif
      output start, abort, window_cycles, input_a, xor_enable, add_enable, ring_i,
      input  adder_a_o, xor_en_o, add_en_o, busy, done, count, overflow
   );

   modport slave (
`ifdef ADDER_OSC_METER_MINMAX_EN
      input  clear_stats,
      output min_count, max_count,
`endif
      input  start, abort, window_cycles, input_a, xor_enable, add_enable, ring_i,
      output adder_a_o, xor_en_o, add_en_o, busy, done, count, overflow
   );
endinterface

// File: rtl/adder_osc_meter_sync_rise_detect.sv
// Two-flop synchroniser followed by a registered rising-edge pulse (3 cycles latency).
module sync_rise_detect
   import adder_osc_meter_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;

   // Synchronise the asynchronous input and flag a 0->1 transition for one cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/adder_osc_meter.sv
// Measurement controller for the instrumented adder chain: drives the latched
// operand/enables into the adder, waits SETTLE cycles, counts ring edges over a
// programmable window and reports a saturating count with a done pulse.
// Optional build macro: ADDER_OSC_METER_MINMAX_EN adds min/max statistics.
module adder_osc_meter
   import adder_osc_meter_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned COUNT_W  = 16,
   parameter int unsigned WINDOW_W = 16,
   parameter int unsigned SETTLE   = 4
)(
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   adder_osc_meter_if.slave   bus
);

   localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_e               state_q, state_d;
   logic [SET_W-1:0]     settle_q, settle_d;
   logic [WINDOW_W-1:0]  win_q, win_d;
   logic [COUNT_W-1:0]   cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic [WIDTH-1:0]     lat_a_q, lat_a_d;
   logic [WIDTH-1:0]     lat_x_q, lat_x_d;
   logic [WIDTH-1:0]     lat_s_q, lat_s_d;
   logic [WIDTH-1:0]     adder_a_q, adder_a_d;
   logic [WIDTH-1:0]     xor_en_q, xor_en_d;
   logic [WIDTH-1:0]     add_en_q, add_en_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic                 ring_rise;
`ifdef ADDER_OSC_METER_MINMAX_EN
   logic [COUNT_W-1:0]   min_q, min_d;
   logic [COUNT_W-1:0]   max_q, max_d;
   logic                 stats_vld_q, stats_vld_d;
`endif

   sync_rise_detect u_ring_sync (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .async_i (bus.ring_i),
      .rise_o  (ring_rise)
   );

   // Next-state, working counters and next values of the registered outputs
   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      win_d      = win_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      lat_a_d    = lat_a_q;
      lat_x_d    = lat_x_q;
      lat_s_d    = lat_s_q;
      count_d    = count_q;
      overflow_d = overflow_q;
`ifdef ADDER_OSC_METER_MINMAX_EN
      min_d       = min_q;
      max_d       = max_q;
      stats_vld_d = stats_vld_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (!bus.abort && bus.start) begin
               state_d  = ST_ARM;
               lat_a_d  = bus.input_a;
               lat_x_d  = bus.xor_enable;
               lat_s_d  = bus.add_enable;
               win_d    = (bus.window_cycles == '0) ? WINDOW_W'(1) : bus.window_cycles;
               settle_d = '0;
               cnt_d    = '0;
               ovf_d    = 1'b0;
            end
         end
         ST_ARM: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (settle_q == SET_W'(SETTLE - 1)) begin
               state_d = ST_MEASURE;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_MEASURE: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else begin
               if (ring_rise) begin
                  if (cnt_q == '1) begin
                     ovf_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + COUNT_W'(1);
                  end
               end
               if (win_q == WINDOW_W'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  win_d = win_q - WINDOW_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d    = (state_d == ST_ARM) || (state_d == ST_MEASURE);
      done_d    = (state_d == ST_DONE);
      adder_a_d = busy_d ? lat_a_d : '0;
      xor_en_d  = busy_d ? lat_x_d : '0;
      add_en_d  = busy_d ? lat_s_d : '0;

      if (done_d) begin
         count_d    = cnt_d;
         overflow_d = ovf_d;
      end

`ifdef ADDER_OSC_METER_MINMAX_EN
      if (done_d) begin
         stats_vld_d = 1'b1;
         if (!stats_vld_q) begin
            min_d = cnt_d;
            max_d = cnt_d;
         end else begin
            if (cnt_d < min_q) min_d = cnt_d;
            if (cnt_d > max_q) max_d = cnt_d;
         end
      end else if ((state_q == ST_IDLE) && bus.clear_stats) begin
         min_d       = '0;
         max_d       = '0;
         stats_vld_d = 1'b0;
      end
`endif
   end

   // State, working registers and output registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         settle_q   <= '0;
         win_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         lat_a_q    <= '0;
         lat_x_q    <= '0;
         lat_s_q    <= '0;
         adder_a_q  <= '0;
         xor_en_q   <= '0;
         add_en_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         win_q      <= win_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         lat_a_q    <= lat_a_d;
         lat_x_q    <= lat_x_d;
         lat_s_q    <= lat_s_d;
         adder_a_q  <= adder_a_d;
         xor_en_q   <= xor_en_d;
         add_en_q   <= add_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef ADDER_OSC_METER_MINMAX_EN
   // Min/max statistics registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         min_q       <= '0;
         max_q       <= '0;
         stats_vld_q <= 1'b0;
      end else begin
         min_q       <= min_d;
         max_q       <= max_d;
         stats_vld_q <= stats_vld_d;
      end
   end

   assign bus.min_count = min_q;
   assign bus.max_count = max_q;
`endif

   assign bus.adder_a_o = adder_a_q;
   assign bus.xor_en_o  = xor_en_q;
   assign bus.add_en_o  = add_en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_adder_osc_meter.sv
// Directed bench for adder_osc_meter with a count/overflow scoreboard.
// A second instance with COUNT_W=4 shares the stimulus to exercise saturation.
module tb_adder_osc_meter;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned COUNT_W  = 16;
   localparam int unsigned WINDOW_W = 16;
   localparam int unsigned SETTLE   = 4;

   typedef struct {
      logic [15:0] cnt;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   ring_period = 0;
   int   ring_ph     = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   adder_osc_meter_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .WINDOW_W(WINDOW_W)) bus ();
   adder_osc_meter_if #(.WIDTH(WIDTH), .COUNT_W(4),       .WINDOW_W(WINDOW_W)) bus4 ();

   adder_osc_meter #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .WINDOW_W(WINDOW_W), .SETTLE(SETTLE)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus.slave)
   );

   adder_osc_meter #(.WIDTH(WIDTH), .COUNT_W(4), .WINDOW_W(WINDOW_W), .SETTLE(SETTLE)) dut4 (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus4.slave)
   );

   assign bus4.start         = bus.start;
   assign bus4.abort         = bus.abort;
   assign bus4.window_cycles = bus.window_cycles;
   assign bus4.input_a       = bus.input_a;
   assign bus4.xor_enable    = bus.xor_enable;
   assign bus4.add_enable    = bus.add_enable;
   assign bus4.ring_i        = bus.ring_i;
`ifdef ADDER_OSC_METER_MINMAX_EN
   assign bus4.clear_stats   = bus.clear_stats;
`endif

   // Free-running ring stand-in: one rising edge every ring_period clocks, 0 = stopped
   always @(posedge clk) begin
      #2;
      if (ring_period == 0) begin
         ring_ph    = 0;
         bus.ring_i = 1'b0;
      end else begin
         ring_ph    = (ring_ph + 1) % ring_period;
         bus.ring_i = (ring_ph < ring_period / 2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start one measurement at cycle 0, return the cycle done appeared and the busy cycle count
   task automatic run(input int win, input logic [7:0] a, input logic [7:0] xe, input logic [7:0] ae,
                      input logic [15:0] exp_cnt, input logic exp_ovf,
                      output int done_cyc, output int busy_cnt);
      exp_t e;
      bus.window_cycles = WINDOW_W'(win);
      bus.input_a       = a;
      bus.xor_enable    = xe;
      bus.add_enable    = ae;
      bus.start         = 1'b1;
      sb.push_back('{exp_cnt, exp_ovf});
      done_cyc = -1;
      busy_cnt = 0;
      for (int c = 1; c <= 2000; c++) begin
         tick();
         bus.start = 1'b0;
         if (c == 1) begin
            chk("arm_adder_a", 32'(bus.adder_a_o), 32'(a));
            chk("arm_xor_en",  32'(bus.xor_en_o),  32'(xe));
            chk("arm_add_en",  32'(bus.add_en_o),  32'(ae));
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cyc = c;
            break;
         end
      end
      e = sb.pop_front();
      chk("sb_count",    32'(bus.count),    32'(e.cnt));
      chk("sb_overflow", 32'(bus.overflow), 32'(e.ovf));
   endtask

   int  dc, bc;
   bit  seen_done;

   initial begin
      rst               = 1'b1;
      bus.start         = 1'b0;
      bus.abort         = 1'b0;
      bus.window_cycles = '0;
      bus.input_a       = '0;
      bus.xor_enable    = '0;
      bus.add_enable    = '0;
`ifdef ADDER_OSC_METER_MINMAX_EN
      bus.clear_stats   = 1'b0;
`endif
      repeat (3) tick();

      // 1: reset state, then idle with a toggling ring
      chk("rst_busy",     32'(bus.busy),      32'd0);
      chk("rst_done",     32'(bus.done),      32'd0);
      chk("rst_count",    32'(bus.count),     32'd0);
      chk("rst_overflow", 32'(bus.overflow),  32'd0);
      chk("rst_adder_a",  32'(bus.adder_a_o), 32'd0);
      chk("rst_xor_en",   32'(bus.xor_en_o),  32'd0);
      chk("rst_add_en",   32'(bus.add_en_o),  32'd0);
      rst = 1'b0;
      ring_period = 2;
      repeat (20) tick();
      chk("idle_busy",    32'(bus.busy),      32'd0);
      chk("idle_count",   32'(bus.count),     32'd0);
      chk("idle_adder_a", 32'(bus.adder_a_o), 32'd0);

      // 2/3: period 4, window 100; saturating 4-bit instance alongside
      ring_period = 4;
      repeat (6) tick();
      run(100, 8'hA5, 8'h3C, 8'hF0, 16'd25, 1'b0, dc, bc);
      chk("p4_done_cycle", 32'(dc), 32'd105);
      chk("p4_busy_cycles", 32'(bc), 32'd104);
      chk("w4_count",    32'(bus4.count),    32'd15);
      chk("w4_overflow", 32'(bus4.overflow), 32'd1);
      tick();
      chk("post_done_pulse", 32'(bus.done),      32'd0);
      chk("post_adder_a",    32'(bus.adder_a_o), 32'd0);
      chk("post_count_hold", 32'(bus.count),     32'd25);

      // 4: window 0 treated as 1, ring stopped
      ring_period = 0;
      repeat (6) tick();
      run(0, 8'h11, 8'h22, 8'h33, 16'd0, 1'b0, dc, bc);
      chk("w0_done_cycle", 32'(dc), 32'(SETTLE + 2));
      chk("w0_xor_en_at_done", 32'(bus.xor_en_o), 32'd0);
      tick();
      chk("w0_add_en_after", 32'(bus.add_en_o), 32'd0);

      // 5: abort 10 cycles into MEASURE after a count of 25
      ring_period = 4;
      repeat (6) tick();
      run(100, 8'h5A, 8'hFF, 8'h0F, 16'd25, 1'b0, dc, bc);
      chk("pre_abort_done_cycle", 32'(dc), 32'd105);
      tick();
      bus.window_cycles = WINDOW_W'(100);
      bus.start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         bus.start = 1'b0;
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_busy",    32'(bus.busy),      32'd0);
      chk("abort_done",    32'(bus.done),      32'd0);
      chk("abort_count",   32'(bus.count),     32'd25);
      chk("abort_adder_a", 32'(bus.adder_a_o), 32'd0);
      seen_done = 1'b0;
      for (int c = 0; c < 120; c++) begin
         tick();
         if (bus.done) seen_done = 1'b1;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);
      run(100, 8'h77, 8'h01, 8'h80, 16'd25, 1'b0, dc, bc);
      chk("restart_done_cycle", 32'(dc), 32'd105);

      // Reset mid-measurement clears everything at once
      tick();
      bus.start = 1'b1;
      repeat (10) tick();
      bus.start = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_busy",    32'(bus.busy),      32'd0);
      chk("midrst_count",   32'(bus.count),     32'd0);
      chk("midrst_adder_a", 32'(bus.adder_a_o), 32'd0);
      tick();
      rst = 1'b0;
      tick();

`ifdef ADDER_OSC_METER_MINMAX_EN
      // 6: min/max over periods 4, 2, 5 then clear
      ring_period = 4;
      repeat (6) tick();
      run(100, 8'h01, 8'h01, 8'h01, 16'd25, 1'b0, dc, bc);
      tick();
      ring_period = 2;
      repeat (6) tick();
      run(100, 8'h01, 8'h01, 8'h01, 16'd50, 1'b0, dc, bc);
      tick();
      ring_period = 5;
      repeat (6) tick();
      run(100, 8'h01, 8'h01, 8'h01, 16'd20, 1'b0, dc, bc);
      tick();
      chk("stats_min", 32'(bus.min_count), 32'd20);
      chk("stats_max", 32'(bus.max_count), 32'd50);
      bus.clear_stats = 1'b1;
      tick();
      bus.clear_stats = 1'b0;
      tick();
      chk("clear_min", 32'(bus.min_count), 32'd0);
      chk("clear_max", 32'(bus.max_count), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
